// File: rtl/padd_pkg.sv
// Shared definitions for the segmented pipelined adder: default geometry,
// the stage-count helper and the beat record that travels down the pipe.
package padd_pkg;

  localparam int PADD_WIDTH = 23;
  localparam int PADD_SEG   = 8;

  // Widest operand the pipe supports; beat fields are sized to this and the
  // unused upper bits are trimmed away by synthesis.
  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  // One beat as seen at the output of a stage: control, the low sum bits
  // resolved so far, the operand bits still waiting for a segment (shifted
  // down so the next segment reads from bit 0) and the carry into that segment.
  typedef struct packed {
    logic  valid;
    logic  sub;
    word_t psum;
    word_t a;
    word_t b;
    logic  carry;
  } beat_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/padd_seg.sv
// One carry-chain segment: W-bit add with carry-in, sum and carry-out
// registered, loading only when enabled.
module padd_seg
  import padd_pkg::*;
#(
  parameter int W = PADD_SEG
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W:0] total;

  // Segment adder, one bit wider than the operands to expose the carry.
  // NOTE: always_comb uses blocking assignments; state in always_ff uses <=.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  end

  // Registered sum/carry; cleared on reset so the pipe output starts at zero.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sum <= '0;
      co  <= 1'b0;
    end else if (en) begin
      sum <= total[W-1:0];
      co  <= total[W];
    end
  end

endmodule

// File: rtl/padd_pipe.sv
// Pipelined adder/subtractor with the carry chain cut into SEG-bit segments,
// one segment per stage, valid/ready handshake with whole-pipe stall.
// Optional macro PADD_SAT_EN: saturate the final result instead of wrapping.
module padd_pipe
  import padd_pkg::*;
#(
  parameter int WIDTH = PADD_WIDTH,
  parameter int SEG   = PADD_SEG
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int STAGES = ceil_div(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  beat_t            in_beat;
  beat_t            view [STAGES];

  // The whole pipe moves in lockstep; an untaken result freezes every stage.
  always_comb begin
    advance = !out_valid || out_ready;
  end

  assign in_ready  = advance;
  assign out_valid = view[LAST].valid;

  // Subtraction is a + ~b + 1: invert B up front and force the carry-in, so
  // every segment is a plain adder and ci is ignored.
  always_comb begin
    b_eff         = sub ? ~b : b;
    in_beat       = '0;
    in_beat.valid = in_valid;
    in_beat.sub   = sub;
    in_beat.a     = word_t'(a);
    in_beat.b     = word_t'(b_eff);
    in_beat.carry = sub | ci;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int W  = (k == LAST) ? (WIDTH - LO) : SEG;

    beat_t        prev;
    logic         vld_q;
    logic         sub_q;
    word_t        psum_q;
    word_t        a_q;
    word_t        b_q;
    logic [W-1:0] seg_sum;
    logic         seg_co;

    if (k == 0) begin : g_head
      assign prev = in_beat;
    end else begin : g_link
      assign prev = view[k-1];
    end

    padd_seg #(.W(W)) u_seg (
      .sys_clk (sys_clk),
      .reset   (reset),
      .en      (advance),
      .a       (prev.a[W-1:0]),
      .b       (prev.b[W-1:0]),
      .ci      (prev.carry),
      .sum     (seg_sum),
      .co      (seg_co)
    );

    // Beat control, resolved low bits and the still-pending operand bits,
    // shifted down by this segment's width for the next stage.
    // NOTE: pending operands carry no reset; valid gates them, so only the
    // control bits and the partial sum (which feeds s) are cleared.
    always_ff @(posedge sys_clk) begin
      if (reset) begin
        vld_q  <= 1'b0;
        sub_q  <= 1'b0;
        psum_q <= '0;
      end else if (advance) begin
        vld_q  <= prev.valid;
        sub_q  <= prev.sub;
        psum_q <= prev.psum;
        a_q    <= prev.a >> W;
        b_q    <= prev.b >> W;
      end
    end

    assign view[k] = '{
      valid: vld_q,
      sub:   sub_q,
      psum:  psum_q | (word_t'(seg_sum) << LO),
      a:     a_q,
      b:     b_q,
      carry: seg_co
    };
  end

  logic [MAX_W:0]   sum_ext;
  logic [WIDTH-1:0] raw_s;
  logic             raw_co;
  logic             unused_bits;

  assign sum_ext = {1'b0, view[LAST].psum};
  assign raw_s   = sum_ext[WIDTH-1:0];
  assign raw_co  = view[LAST].carry;

`ifdef PADD_SAT_EN
  // Clamp on overflow (add) or borrow (sub); co already carries the right flag.
  always_comb begin
    s  = raw_s;
    co = raw_co;
    if (!view[LAST].sub && raw_co) begin
      s = '1;
    end else if (view[LAST].sub && !raw_co) begin
      s = '0;
    end
  end

  assign unused_bits = ^{view[LAST].a, view[LAST].b, sum_ext[MAX_W:WIDTH]};
`else
  assign s  = raw_s;
  assign co = raw_co;

  assign unused_bits = ^{view[LAST].a, view[LAST].b, view[LAST].sub,
                         sum_ext[MAX_W:WIDTH]};
`endif

endmodule
